// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg
// Shared types and constants for the serial frame aligner/checker.
//   sync_state_t     : alignment state machine encoding (also the SyncState port value)
//   DEFAULT_WORD_ID  : identifier placed in the header field of every frame
//   *_MSB / *_LSB    : field offsets of the 40-bit frame (header, data, trailer,
//                      filler), so that design and bench monitors decode frames
//                      identically
//   frame_header()   : extracts the header field from a captured frame
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam logic [15:0] DEFAULT_WORD_ID = 16'h3C5C;

    localparam int FRAME_W  = 40;
    localparam int HDR_MSB  = 39;
    localparam int HDR_LSB  = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 8;
    localparam int TRL_MSB  = 7;
    localparam int TRL_LSB  = 4;
    localparam int FILL_MSB = 3;
    localparam int FILL_LSB = 0;

    // Index of each statistics counter in the counter bank.
    localparam int NUM_COUNTERS = 4;
    localparam int CNT_FRAME    = 0;
    localparam int CNT_REALIGN  = 1;
    localparam int CNT_LOSS     = 2;
    localparam int CNT_MISS     = 3;

    function automatic logic [HDR_MSB-HDR_LSB:0] frame_header(input logic [FRAME_W-1:0] frame);
        return frame[HDR_MSB:HDR_LSB];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating event counter with synchronous clear.
//   clk : clock
//   rst : asynchronous active-high reset (count -> 0)
//   inc : count one event this cycle
//   clr : synchronous clear; takes priority over inc
//   q   : current count, holds at all-ones once reached
module sat_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign q = count_reg;

endmodule

// File: rtl/frame_sync_checker.sv
// frame_sync_checker
// Deserialises a 1-bit link (LSB first), hunts for the frame identifier and
// qualifies alignment through HUNT -> VERIFY -> LOCKED with lock/unlock
// hysteresis and a header-gap timeout. Aligned words are emitted in parallel.
//   CLK1280       : bit-rate clock
//   RST           : asynchronous active-high reset
//   BitEn         : one serial bit per high cycle (rate selection)
//   DataIn        : serial data, sampled when BitEn=1
//   ClearCounters : synchronous clear of all statistics
//   WordOut       : last captured word
//   WordValid     : one-cycle strobe, WordOut is new
//   WordIsHeader  : WordOut carried an aligned identifier
//   Locked        : state is LOCKED
//   SyncState     : 0 HUNT, 1 VERIFY, 2 LOCKED
//   FrameCount    : aligned headers seen while LOCKED
//   ReAlignCount  : identifiers at an unexpected phase in VERIFY/LOCKED
//   LossCount     : LOCKED -> HUNT transitions
//   MissCount     : header-gap timeouts
module frame_sync_checker
    import frame_sync_pkg::*;
#(
    parameter int                WORD_W   = 40,
    parameter int                ID_W     = 16,
    parameter logic [ID_W-1:0]   WORD_ID  = ID_W'(DEFAULT_WORD_ID),
    parameter int                LOCK_N   = 4,
    parameter int                UNLOCK_N = 2,
    parameter int                MAX_GAP  = 4096,
    parameter int                CNT_W    = 24
) (
    input  logic              CLK1280,
    input  logic              RST,
    input  logic              BitEn,
    input  logic              DataIn,
    input  logic              ClearCounters,
    output logic [WORD_W-1:0] WordOut,
    output logic              WordValid,
    output logic              WordIsHeader,
    output logic              Locked,
    output logic [1:0]        SyncState,
    output logic [CNT_W-1:0]  FrameCount,
    output logic [CNT_W-1:0]  ReAlignCount,
    output logic [CNT_W-1:0]  LossCount,
    output logic [CNT_W-1:0]  MissCount
);

    localparam int PH_W   = $clog2(WORD_W);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(UNLOCK_N + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);

    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(WORD_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_N);
    localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(UNLOCK_N);
    localparam logic [GAP_W-1:0]  GAP_TARGET  = GAP_W'(MAX_GAP);

    sync_state_t        state_reg, state_next;
    logic [WORD_W-1:0]  sr_reg, sr_next;
    logic [PH_W-1:0]    ph_reg, ph_next;
    logic [GOOD_W-1:0]  good_reg, good_next;
    logic [BAD_W-1:0]   bad_reg, bad_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [WORD_W-1:0]  word_out_reg, word_out_next;
    logic               word_valid_reg, word_valid_next;
    logic               word_is_header_reg, word_is_header_next;

    logic               match;
    logic               boundary;
    logic               aligned;
    logic               misaligned;
    logic               unlock;
    logic               timeout;
    logic [NUM_COUNTERS-1:0] cnt_inc;
    logic [CNT_W-1:0]        cnt_q [NUM_COUNTERS];

    // Identifier check on the window before this cycle's bit is shifted in.
    assign match      = (sr_reg[WORD_W-1 -: ID_W] == WORD_ID);
    assign boundary   = BitEn && (ph_reg == PH_LAST);
    assign aligned    = boundary && match;
    assign misaligned = BitEn && !boundary && match;

    always_ff @(posedge CLK1280 or posedge RST) begin
        if (RST) begin
            state_reg          <= HUNT;
            sr_reg             <= '0;
            ph_reg             <= '0;
            good_reg           <= '0;
            bad_reg            <= '0;
            gap_reg            <= '0;
            word_out_reg       <= '0;
            word_valid_reg     <= 1'b0;
            word_is_header_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            sr_reg             <= sr_next;
            ph_reg             <= ph_next;
            good_reg           <= good_next;
            bad_reg            <= bad_next;
            gap_reg            <= gap_next;
            word_out_reg       <= word_out_next;
            word_valid_reg     <= word_valid_next;
            word_is_header_reg <= word_is_header_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        sr_next             = sr_reg;
        ph_next             = ph_reg;
        good_next           = good_reg;
        bad_next            = bad_reg;
        gap_next            = gap_reg;
        word_out_next       = word_out_reg;
        word_valid_next     = 1'b0;
        word_is_header_next = word_is_header_reg;
        unlock              = 1'b0;
        timeout             = 1'b0;
        cnt_inc             = '0;

        if (BitEn) begin
            sr_next = {DataIn, sr_reg[WORD_W-1:1]};
            ph_next = (ph_reg == PH_LAST) ? '0 : ph_reg + PH_W'(1);

            if (state_reg != HUNT) begin
                if (boundary) begin
                    word_out_next       = sr_reg;
                    word_valid_next     = 1'b1;
                    word_is_header_next = match;
                end
                if (aligned) begin
                    gap_next = '0;
                end else if (boundary) begin
                    gap_next = gap_reg + GAP_W'(1);
                    timeout  = (gap_next == GAP_TARGET);
                end
            end else begin
                // The header-gap timer only measures time since alignment.
                gap_next = '0;
            end

            case (state_reg)
                HUNT: begin
                    if (match) begin
                        // Restart the phase so the next boundary falls exactly
                        // one word after this identifier.
                        ph_next    = '0;
                        good_next  = GOOD_W'(1);
                        bad_next   = '0;
                        state_next = (LOCK_N == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (aligned) begin
                        good_next = good_reg + GOOD_W'(1);
                        if (good_next == GOOD_TARGET) begin
                            state_next = LOCKED;
                            bad_next   = '0;
                        end
                    end else if (misaligned) begin
                        ph_next                = '0;
                        good_next              = GOOD_W'(1);
                        cnt_inc[CNT_REALIGN]   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        cnt_inc[CNT_FRAME] = 1'b1;
                        bad_next           = '0;
                    end else if (misaligned) begin
                        // Phase is kept: a lone glitch must not disturb a good lock.
                        cnt_inc[CNT_REALIGN] = 1'b1;
                        bad_next             = bad_reg + BAD_W'(1);
                        unlock               = (bad_next == BAD_TARGET);
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase

            // Unlock and timeout share one exit so coincident causes count one loss.
            if (unlock || timeout) begin
                state_next         = HUNT;
                good_next          = '0;
                bad_next           = '0;
                gap_next           = '0;
                cnt_inc[CNT_LOSS]  = (state_reg == LOCKED);
            end
            cnt_inc[CNT_MISS] = timeout;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counters
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk (CLK1280),
                .rst (RST),
                .inc (cnt_inc[gi]),
                .clr (ClearCounters),
                .q   (cnt_q[gi])
            );
        end
    endgenerate

    assign WordOut      = word_out_reg;
    assign WordValid    = word_valid_reg;
    assign WordIsHeader = word_is_header_reg;
    assign Locked       = (state_reg == LOCKED);
    assign SyncState    = state_reg;
    assign FrameCount   = cnt_q[CNT_FRAME];
    assign ReAlignCount = cnt_q[CNT_REALIGN];
    assign LossCount    = cnt_q[CNT_LOSS];
    assign MissCount    = cnt_q[CNT_MISS];

endmodule

// File: tb/tb_frame_sync_checker.sv
// tb_frame_sync_checker
// Directed stimulus with a scoreboard: expected emitted words are queued by the
// stimulus thread and consumed by an independent monitor on each WordValid.
module tb_frame_sync_checker;
    import frame_sync_pkg::*;

    localparam int WORD_W = 40;
    localparam int CNT_W  = 24;
    localparam int GAP    = 8;

    logic              CLK1280;
    logic              RST;
    logic              BitEn;
    logic              DataIn;
    logic              ClearCounters;
    logic [WORD_W-1:0] WordOut;
    logic              WordValid;
    logic              WordIsHeader;
    logic              Locked;
    logic [1:0]        SyncState;
    logic [CNT_W-1:0]  FrameCount;
    logic [CNT_W-1:0]  ReAlignCount;
    logic [CNT_W-1:0]  LossCount;
    logic [CNT_W-1:0]  MissCount;

    frame_sync_checker #(
        .MAX_GAP(GAP)
    ) dut (
        .CLK1280       (CLK1280),
        .RST           (RST),
        .BitEn         (BitEn),
        .DataIn        (DataIn),
        .ClearCounters (ClearCounters),
        .WordOut       (WordOut),
        .WordValid     (WordValid),
        .WordIsHeader  (WordIsHeader),
        .Locked        (Locked),
        .SyncState     (SyncState),
        .FrameCount    (FrameCount),
        .ReAlignCount  (ReAlignCount),
        .LossCount     (LossCount),
        .MissCount     (MissCount)
    );

    initial CLK1280 = 1'b0;
    always #5 CLK1280 = ~CLK1280;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              hdr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_period = 0;
    int   cyc = 0;

    always @(posedge CLK1280) cyc++;

    // Monitor: every emitted word must match the head of the scoreboard.
    int  last_valid_cyc = 0;
    bit  have_last = 1'b0;
    always @(negedge CLK1280) begin
        exp_t e;
        if (RST) begin
            have_last = 1'b0;
        end else if (WordValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got WordOut=%h hdr=%0b, none expected", WordOut, WordIsHeader);
            end else begin
                e = exp_q.pop_front();
                if (WordOut !== e.word || WordIsHeader !== e.hdr) begin
                    errors++;
                    $display("FAIL word: got %h hdr=%0b, expected %h hdr=%0b", WordOut, WordIsHeader, e.word, e.hdr);
                end else begin
                    $display("word %h hdr=%0b header_field=%h ok", WordOut, WordIsHeader, frame_header(WordOut));
                end
            end
            if (exp_period != 0 && have_last) begin
                checks++;
                if (cyc - last_valid_cyc != exp_period) begin
                    errors++;
                    $display("FAIL valid_period: got %0d cycles, expected %0d", cyc - last_valid_cyc, exp_period);
                end
            end
            last_valid_cyc = cyc;
            have_last      = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    // Payload bits never contain four consecutive ones, so the identifier can
    // only be found where a header was actually placed.
    function automatic logic [23:0] mk_data(input int k);
        logic [3:0] kk;
        kk = k[3:0];
        return {8'h5A, 8'h24, kk[1:0], 1'b0, kk[3:2], 1'b0, 2'b01};
    endfunction

    function automatic logic [WORD_W-1:0] hdr_word(input int k);
        return {DEFAULT_WORD_ID, mk_data(k)};
    endfunction

    function automatic logic [WORD_W-1:0] fill_word(input int k);
        return {16'h0000, mk_data(k)};
    endfunction

    task automatic push(input logic [WORD_W-1:0] w, input logic h);
        exp_t e;
        e.word = w;
        e.hdr  = h;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int div, input logic clr);
        DataIn        = b;
        BitEn         = 1'b1;
        ClearCounters = clr;
        @(posedge CLK1280);
        #1;
        BitEn         = 1'b0;
        ClearCounters = 1'b0;
        for (int k = 1; k < div; k++) begin
            @(posedge CLK1280);
            #1;
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int div, input logic clr_first);
        for (int i = 0; i < WORD_W; i++) send_bit(w[i], div, clr_first && (i == 0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_WordOut"}, 64'(WordOut), 64'd0);
        chk({tag, "_WordValid"}, 64'(WordValid), 64'd0);
        chk({tag, "_WordIsHeader"}, 64'(WordIsHeader), 64'd0);
        chk({tag, "_Locked"}, 64'(Locked), 64'd0);
        chk({tag, "_SyncState"}, 64'(SyncState), 64'd0);
        chk({tag, "_FrameCount"}, 64'(FrameCount), 64'd0);
        chk({tag, "_ReAlignCount"}, 64'(ReAlignCount), 64'd0);
        chk({tag, "_LossCount"}, 64'(LossCount), 64'd0);
        chk({tag, "_MissCount"}, 64'(MissCount), 64'd0);
    endtask

    initial begin
        logic [WORD_W-1:0] w13;
        logic [WORD_W-1:0] w14;
        logic [WORD_W-1:0] w39;

        RST = 1'b1; BitEn = 1'b0; DataIn = 1'b0; ClearCounters = 1'b0;
        repeat (3) @(posedge CLK1280);
        #1;
        RST = 1'b0;
        @(posedge CLK1280);
        #1;
        check_all_zero("reset");

        // Lock at 1280 Mbps: word0 found in HUNT, words 1..3 verify, lock on word3.
        for (int k = 1; k <= 7; k++) push(hdr_word(k), 1'b1);
        for (int k = 0; k <= 3; k++) send_word(hdr_word(k), 1, 1'b0);
        chk("verify_state", 64'(SyncState), 64'd1);
        chk("verify_not_locked", 64'(Locked), 64'd0);
        send_word(hdr_word(4), 1, 1'b0);
        chk("locked_state", 64'(SyncState), 64'd2);
        chk("locked_flag", 64'(Locked), 64'd1);
        chk("frame_at_lock", 64'(FrameCount), 64'd0);
        for (int k = 5; k <= 7; k++) send_word(hdr_word(k), 1, 1'b0);
        chk("frame_after_7", 64'(FrameCount), 64'd3);

        // Same stream at 640 Mbps: identical words, one strobe per 80 cycles.
        for (int k = 8; k <= 11; k++) push(hdr_word(k), 1'b1);
        send_word(hdr_word(8), 2, 1'b0);
        exp_period = 80;
        for (int k = 9; k <= 11; k++) send_word(hdr_word(k), 2, 1'b0);
        exp_period = 0;
        chk("frame_after_11", 64'(FrameCount), 64'd7);

        // Two headers each shifted by 7 bits while locked -> unlock, then relock.
        w13 = hdr_word(13);
        w14 = hdr_word(14);
        push(hdr_word(12), 1'b1);
        push({w13[32:0], 7'b0}, 1'b0);
        push({w14[25:0], 7'b0, w13[39:33]}, 1'b0);
        for (int k = 16; k <= 18; k++) push(hdr_word(k), 1'b1);
        send_word(hdr_word(12), 1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1, 1'b0);
        send_word(w13, 1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1, 1'b0);
        send_word(w14, 1, 1'b0);
        send_word(hdr_word(15), 1, 1'b0);
        chk("realign_count", 64'(ReAlignCount), 64'd2);
        chk("loss_after_realign", 64'(LossCount), 64'd1);
        chk("hunt_after_realign", 64'(SyncState), 64'd0);
        chk("frame_before_unlock", 64'(FrameCount), 64'd9);
        for (int k = 16; k <= 18; k++) send_word(hdr_word(k), 1, 1'b0);

        // Clear on an idle (BitEn=0) cycle, then starve headers while locked.
        ClearCounters = 1'b1;
        @(posedge CLK1280);
        #1;
        ClearCounters = 1'b0;
        chk("clear_idle_realign", 64'(ReAlignCount), 64'd0);
        push(hdr_word(19), 1'b1);
        for (int k = 20; k <= 27; k++) push(fill_word(k), 1'b0);
        send_word(hdr_word(19), 1, 1'b0);
        chk("relocked_state", 64'(SyncState), 64'd2);
        for (int k = 20; k <= 31; k++) send_word(fill_word(k), 1, 1'b0);
        chk("miss_count", 64'(MissCount), 64'd1);
        chk("loss_after_timeout", 64'(LossCount), 64'd1);
        chk("hunt_after_timeout", 64'(SyncState), 64'd0);
        chk("frame_before_timeout", 64'(FrameCount), 64'd1);

        // Relock, then clear in the very cycle of a FrameCount increment.
        for (int k = 33; k <= 38; k++) push(hdr_word(k), 1'b1);
        for (int k = 32; k <= 36; k++) send_word(hdr_word(k), 1, 1'b0);
        chk("frame_before_clear", 64'(FrameCount), 64'd1);
        send_word(hdr_word(37), 1, 1'b1);
        chk("clear_wins_frame", 64'(FrameCount), 64'd0);
        chk("clear_wins_miss", 64'(MissCount), 64'd0);
        send_word(hdr_word(38), 1, 1'b0);
        chk("frame_after_clear", 64'(FrameCount), 64'd1);

        // Reset for one cycle mid-word while locked.
        w39 = hdr_word(39);
        for (int i = 0; i < 20; i++) send_bit(w39[i], 1, 1'b0);
        chk("frame_before_reset", 64'(FrameCount), 64'd2);
        RST = 1'b1;
        @(posedge CLK1280);
        #1;
        RST = 1'b0;
        check_all_zero("midword_reset");

        for (int k = 41; k <= 44; k++) push(hdr_word(k), 1'b1);
        for (int k = 40; k <= 43; k++) send_word(hdr_word(k), 1, 1'b0);
        chk("reverify_state", 64'(SyncState), 64'd1);
        send_word(hdr_word(44), 1, 1'b0);
        chk("relock_after_reset", 64'(SyncState), 64'd2);
        send_word(hdr_word(45), 1, 1'b0);
        chk("frame_after_relock", 64'(FrameCount), 64'd1);

        repeat (4) @(posedge CLK1280);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
